// File: rtl/vectorsum_pkg.sv
// vectorsum_pkg
// Shared types and default sizing for the vector-sum readout path.
//   readout_state_t    : readout FSM encoding (IDLE / RUN / DRAIN)
//   DEFAULT_*          : default element width, z-memory address width, vector length
//   read_slot_free()   : read-issue credit check against the 2-entry output FIFO
package vectorsum_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 32;
  localparam int DEFAULT_ADDR_WIDTH  = 10;
  localparam int DEFAULT_VECTOR_SIZE = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } readout_state_t;

  // A new read may be issued only if the entries still buffered after this
  // cycle's pop, plus the read already in flight, leave a FIFO slot for it.
  // Discounting the pop is what lets a full-rate stream issue every cycle.
  function automatic logic read_slot_free(input logic [1:0] fifo_count,
                                          input logic       popping,
                                          input logic       in_flight);
    logic [2:0] occupancy;
    occupancy = {1'b0, fifo_count} - {2'b00, popping} + {2'b00, in_flight};
    return (occupancy < 3'd2);
  endfunction

endpackage

// File: rtl/vectorsum_readout_stream_fifo2.sv
// stream_fifo2
// Two-entry synchronous FIFO holding streamed elements (data plus last flag).
//   clock, reset : rising-edge clock, synchronous active-high reset
//   push, data   : write request and write payload
//   pop          : read request (ignored while empty)
//   head         : oldest entry, stable until popped
//   valid        : FIFO non-empty
//   count        : number of stored entries (0..2)
module stream_fifo2 #(
  parameter int WIDTH = 33
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] slot [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       level;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = pop & (level != 2'd0);
  assign do_push = push & ((level != 2'd2) | do_pop);

  // Storage, pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      slot[0] <= {WIDTH{1'b0}};
      slot[1] <= {WIDTH{1'b0}};
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      level   <= 2'd0;
    end else begin
      if (do_push) begin
        slot[wr_ptr] <= data;
        wr_ptr       <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 2'd1;
        2'b01:   level <= level - 2'd1;
        default: level <= level;
      endcase
    end
  end

  assign head  = slot[rd_ptr];
  assign valid = (level != 2'd0);
  assign count = level;

endmodule

// File: rtl/vectorsum_readout.sv
// vectorsum_readout
// Streams a vector out of the z result memory and accumulates its total.
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   start / done        : pass request (sampled in IDLE) / pass complete flag
//   z_addr / z_dout     : z-memory read address / read data (1-cycle latency)
//   out_data, out_last  : streamed element and end-of-vector marker
//   out_valid/out_ready : stream handshake
//   sum                 : wrap-around signed total of accepted beats
module vectorsum_readout
  import vectorsum_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int VECTOR_SIZE = DEFAULT_VECTOR_SIZE
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] z_addr,
  input  logic [DATA_WIDTH-1:0] z_dout,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [DATA_WIDTH-1:0] sum
);

  // One spare bit so a full 2**ADDR_WIDTH pass never wraps the counter.
  localparam int                CW       = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]     LAST_IDX = CW'(VECTOR_SIZE - 1);

  readout_state_t       state;
  readout_state_t       state_next;
  logic [CW-1:0]        issue_count;
  logic                 issue;
  logic                 last_issue;
  logic                 in_flight;
  logic                 in_flight_last;
  logic                 accept;
  logic                 fifo_valid;
  logic [1:0]           fifo_count;
  logic [DATA_WIDTH:0]  fifo_head;

  assign accept     = fifo_valid & out_ready;
  assign last_issue = (issue_count == LAST_IDX);

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (issue && last_issue) begin
          state_next = DRAIN;
        end else begin
          state_next = RUN;
        end
      end
      DRAIN: begin
        // fifo_head[0] is the last flag of the beat being accepted.
        if (accept && fifo_head[0]) begin
          state_next = IDLE;
        end else begin
          state_next = DRAIN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: read issue and its address (zero when nothing is issued).
  always_comb begin
    issue  = 1'b0;
    z_addr = {ADDR_WIDTH{1'b0}};
    case (state)
      RUN: begin
        issue = read_slot_free(fifo_count, accept, in_flight);
        if (issue) begin
          z_addr = issue_count[ADDR_WIDTH-1:0];
        end else begin
          z_addr = {ADDR_WIDTH{1'b0}};
        end
      end
      default: begin
        issue  = 1'b0;
        z_addr = {ADDR_WIDTH{1'b0}};
      end
    endcase
  end

  // Issue counter, in-flight read tracking, running sum and done flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      issue_count    <= {CW{1'b0}};
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
      sum            <= {DATA_WIDTH{1'b0}};
      done           <= 1'b0;
    end else begin
      in_flight      <= issue;
      in_flight_last <= issue & last_issue;
      if ((state == IDLE) && start) begin
        issue_count <= {CW{1'b0}};
        sum         <= {DATA_WIDTH{1'b0}};
        done        <= 1'b0;
      end else begin
        if (issue) begin
          issue_count <= issue_count + {{ADDR_WIDTH{1'b0}}, 1'b1};
        end
        if (accept) begin
          sum <= DATA_WIDTH'($signed(sum) + $signed(out_data));
        end
        if ((state == DRAIN) && accept && fifo_head[0]) begin
          done <= 1'b1;
        end
      end
    end
  end

  // Read data lands one cycle after issue; the credit check keeps it from overflowing.
  stream_fifo2 #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (in_flight),
    .data  ({z_dout, in_flight_last}),
    .pop   (accept),
    .head  (fifo_head),
    .valid (fifo_valid),
    .count (fifo_count)
  );

  assign out_valid = fifo_valid;
  assign out_data  = fifo_head[DATA_WIDTH:1];
  assign out_last  = fifo_valid & fifo_head[0];

endmodule

// File: tb/tb_vectorsum_readout.sv
module tb_vectorsum_readout;

  localparam int NI = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_v     [NI];
  logic        out_ready_v [NI];
  logic        done_v      [NI];
  logic [9:0]  z_addr_v    [NI];
  logic [31:0] z_dout_v    [NI];
  logic [31:0] out_data_v  [NI];
  logic        out_valid_v [NI];
  logic        out_last_v  [NI];
  logic [31:0] sum_v       [NI];

  logic [31:0] zmem [NI][1024];
  logic [32:0] exp_q [$];
  logic [31:0] exp_sum;
  int          vs_tab [NI] = '{8, 2, 1, 1024};
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  // Instance 0: VS=8, 1: VS=2, 2: VS=1, 3: VS=1024 (all ADDR_WIDTH=10).
  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int VS = (g == 0) ? 8 : (g == 1) ? 2 : (g == 2) ? 1 : 1024;
    vectorsum_readout #(
      .DATA_WIDTH  (32),
      .ADDR_WIDTH  (10),
      .VECTOR_SIZE (VS)
    ) u_dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start_v[g]),
      .done      (done_v[g]),
      .z_addr    (z_addr_v[g]),
      .z_dout    (z_dout_v[g]),
      .out_data  (out_data_v[g]),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready_v[g]),
      .out_last  (out_last_v[g]),
      .sum       (sum_v[g])
    );
  end

  // z memories with one-cycle read latency.
  always @(posedge clock) begin
    for (int g = 0; g < NI; g++) begin
      z_dout_v[g] <= zmem[g][z_addr_v[g]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic ready_for(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // One pass on instance g. mode: 0 ready high, 1 pattern 1,0,0,1, 2 random.
  // hold keeps start high for the whole pass; abort_n>0 resets after that many beats.
  task automatic run_pass(input int g, input int mode, input bit hold, input int abort_n);
    int          vs;
    int          cyc;
    int          first_cyc;
    int          last_cyc;
    int          beats;
    bit          got_last;
    bit          held_v;
    logic [31:0] held_d;
    logic [32:0] e;
    logic [31:0] part_sum;
    logic [9:0]  last_addr;
    vs = vs_tab[g];
    exp_q.delete();
    exp_sum = 32'd0;
    for (int k = 0; k < vs; k++) begin
      exp_q.push_back({(k == vs - 1), zmem[g][k]});
      exp_sum = exp_sum + zmem[g][k];
    end
    @(posedge clock); #1;
    start_v[g] = 1'b1;
    out_ready_v[g] = ready_for(mode, 0);
    @(posedge clock); #1;
    if (!hold) start_v[g] = 1'b0;
    @(negedge clock);
    chk("done_cleared", 64'(done_v[g]), 64'(0));
    chk("sum_cleared", 64'(sum_v[g]), 64'(0));
    cyc = 0; first_cyc = -1; last_cyc = -1; beats = 0;
    got_last = 1'b0; held_v = 1'b0; held_d = 32'd0; part_sum = 32'd0; last_addr = 10'd0;
    while (cyc < 5000) begin
      if (z_addr_v[g] != 10'd0) last_addr = z_addr_v[g];
      if (out_valid_v[g]) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (held_v) chk("stall_stable", 64'(out_data_v[g]), 64'(held_d));
        if (out_ready_v[g]) begin
          checks++;
          assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL extra_beat observed=%0h expected=none", out_data_v[g]);
          end
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("beat", 64'({out_last_v[g], out_data_v[g]}), 64'(e));
            part_sum = part_sum + e[31:0];
          end
          beats++;
          if (out_last_v[g]) begin
            got_last = 1'b1;
            last_cyc = cyc;
          end
        end
      end
      held_v = out_valid_v[g] & ~out_ready_v[g];
      held_d = out_data_v[g];
      if ((abort_n > 0) && (beats == abort_n)) begin
        @(posedge clock); #1;
        chk("partial_sum", 64'(sum_v[g]), 64'(part_sum));
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("rst_valid", 64'(out_valid_v[g]), 64'(0));
        chk("rst_last", 64'(out_last_v[g]), 64'(0));
        chk("rst_done", 64'(done_v[g]), 64'(0));
        chk("rst_sum", 64'(sum_v[g]), 64'(0));
        reset = 1'b0;
        exp_q.delete();
        return;
      end
      @(posedge clock); #1;
      cyc++;
      out_ready_v[g] = ready_for(mode, cyc);
      @(negedge clock);
      if (got_last) break;
    end
    chk("pass_complete", 64'(got_last), 64'(1));
    chk("first_beat_latency", 64'(first_cyc), 64'(2));
    if (mode == 0) chk("back_to_back", 64'(last_cyc - first_cyc), 64'(vs - 1));
    chk("beat_count", 64'(beats), 64'(vs));
    chk("done_after_last", 64'(done_v[g]), 64'(1));
    chk("valid_after_last", 64'(out_valid_v[g]), 64'(0));
    chk("sum_model", 64'(sum_v[g]), 64'(exp_sum));
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    if (vs > 1) chk("last_addr", 64'(last_addr), 64'(vs - 1));
    if (hold) begin
      start_v[g] = 1'b0;
      repeat (3) @(negedge clock);
      chk("no_restart_valid", 64'(out_valid_v[g]), 64'(0));
      chk("no_restart_done", 64'(done_v[g]), 64'(1));
      chk("idle_zaddr", 64'(z_addr_v[g]), 64'(0));
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int g = 0; g < NI; g++) begin
      start_v[g] = 1'b0;
      out_ready_v[g] = 1'b0;
      for (int k = 0; k < 1024; k++) zmem[g][k] = 32'd0;
    end
    for (int k = 0; k < 8; k++) zmem[0][k] = 32'(k + 1);
    zmem[1][0] = 32'h7FFF_FFFF;
    zmem[1][1] = 32'h7FFF_FFFF;
    zmem[2][0] = 32'hA5A5_0001;
    for (int k = 0; k < 1024; k++) zmem[3][k] = 32'(k) * 32'h9E37_79B1 + 32'h1234_5678;

    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int g = 0; g < NI; g++) begin
      chk("reset_valid", 64'(out_valid_v[g]), 64'(0));
      chk("reset_last", 64'(out_last_v[g]), 64'(0));
      chk("reset_done", 64'(done_v[g]), 64'(0));
      chk("reset_sum", 64'(sum_v[g]), 64'(0));
      chk("reset_zaddr", 64'(z_addr_v[g]), 64'(0));
    end
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("post_reset_valid", 64'(out_valid_v[0]), 64'(0));

    run_pass(0, 0, 1'b0, 0);
    chk("sum_36", 64'(sum_v[0]), 64'(36));
    run_pass(0, 1, 1'b0, 0);
    run_pass(0, 0, 1'b1, 0);
    run_pass(0, 0, 1'b0, 0);
    run_pass(0, 0, 1'b0, 3);
    run_pass(0, 0, 1'b0, 0);
    run_pass(1, 0, 1'b0, 0);
    chk("sum_wrap", 64'(sum_v[1]), 64'(32'hFFFF_FFFE));
    run_pass(2, 1, 1'b0, 0);
    run_pass(3, 2, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
